// File: rtl/rng_axis_pkg.sv
// Shared definitions for the TRNG stream output path: FIFO word layout and AXIS constants.
package rng_axis_pkg;

  localparam int         WORD_W   = 33;
  localparam int         LAST_BIT = 32;
  localparam logic [3:0] KEEP_ALL = 4'hF;

  typedef struct packed {
    logic        last;
    logic [31:0] data;
  } rng_word_t;

  function automatic rng_word_t unpack_word(input logic [WORD_W-1:0] w);
    rng_word_t r;
    r.last = w[LAST_BIT];
    r.data = w[31:0];
    return r;
  endfunction

endpackage

// File: rtl/rng_axis_buf.sv
// Circular output buffer of BUF_DEPTH words; the caller's credit scheme guarantees no push when full.
module rng_axis_buf
  import rng_axis_pkg::*;
#(
  parameter int BUF_DEPTH = 2,
  localparam int PTR_W    = $clog2(BUF_DEPTH)
) (
  input  logic           CLK,
  input  logic           RST,
  input  logic           CLR,
  input  logic           PUSH,
  input  rng_word_t      PUSH_WORD,
  input  logic           POP,
  output logic [PTR_W:0] OCC,
  output rng_word_t      HEAD
);

  rng_word_t        mem [BUF_DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W:0]   occ;
  logic             do_pop;

  assign do_pop = POP & (occ != '0);

  always_ff @(posedge CLK) begin
    if (RST || CLR) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      occ    <= '0;
    end else begin
      if (PUSH)   wr_ptr <= wr_ptr + 1'b1;
      if (do_pop) rd_ptr <= rd_ptr + 1'b1;
      case ({PUSH, do_pop})
        2'b10:   occ <= occ + 1'b1;
        2'b01:   occ <= occ - 1'b1;
        default: occ <= occ;
      endcase
    end
  end

  // Storage carries data only; validity is tracked by occ alone.
  always_ff @(posedge CLK) begin
    if (PUSH) mem[wr_ptr] <= PUSH_WORD;
  end

  assign OCC  = occ;
  assign HEAD = mem[rd_ptr];

endmodule

// File: rtl/rng_axis_out.sv
// TRNG word FIFO reader presenting {last,data} words as an AXI4-Stream master with beat/packet counters.
// Defining RNG_AXIS_STALL_CNT_EN adds a saturating TVALID & ~TREADY cycle counter on STALL_CYCLES.
module rng_axis_out
  import rng_axis_pkg::*;
#(
  parameter int BUF_DEPTH = 2,
  parameter int CNT_W     = 32
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic [32:0]       FIFO_DOUT,
  input  logic              FIFO_EMPTY,
  output logic              FIFO_RE,
  input  logic              STOP,
  output logic [31:0]       M_TDATA,
  output logic [3:0]        M_TKEEP,
  output logic              M_TLAST,
  output logic              M_TVALID,
  input  logic              M_TREADY,
  output logic              BUSY,
  output logic [CNT_W-1:0]  SENT_BEATS,
  output logic [CNT_W-1:0]  SENT_PKTS,
  output logic [31:0]       STALL_CYCLES
);

  localparam int PTR_W = $clog2(BUF_DEPTH);

  logic             credit;
  logic             rd_vld_p1;
  rng_word_t        rd_word_p1;
  logic             push_p1;
  logic [PTR_W:0]   occ_p2;
  rng_word_t        head_p2;
  logic             out_vld_p2;
  logic             hs_p2;
  logic [CNT_W-1:0] beat_cnt;
  logic [CNT_W-1:0] pkt_cnt;

  // Stage 0: issue a read only when a buffer slot is already reserved for it
  assign credit  = (int'(occ_p2) + int'(rd_vld_p1)) < BUF_DEPTH;
  assign FIFO_RE = ~FIFO_EMPTY & ~STOP & ~RST & credit;

  always_ff @(posedge CLK) begin
    if (RST || STOP) rd_vld_p1 <= 1'b0;
    else             rd_vld_p1 <= FIFO_RE;
  end

  // Stage 1: FIFO data is valid the cycle after the strobe
  assign rd_word_p1 = unpack_word(FIFO_DOUT);
  assign push_p1    = rd_vld_p1 & ~STOP;

  rng_axis_buf #(
    .BUF_DEPTH (BUF_DEPTH)
  ) u_buf (
    .CLK       (CLK),
    .RST       (RST),
    .CLR       (STOP),
    .PUSH      (push_p1),
    .PUSH_WORD (rd_word_p1),
    .POP       (hs_p2),
    .OCC       (occ_p2),
    .HEAD      (head_p2)
  );

  // Stage 2: buffer head drives the stream
  assign out_vld_p2 = (occ_p2 != '0);
  assign hs_p2      = out_vld_p2 & M_TREADY & ~STOP;

  assign M_TVALID = out_vld_p2;
  assign M_TDATA  = out_vld_p2 ? head_p2.data : 32'd0;
  assign M_TLAST  = out_vld_p2 & head_p2.last;
  assign M_TKEEP  = KEEP_ALL;
  assign BUSY     = out_vld_p2 | rd_vld_p1;

  always_ff @(posedge CLK) begin
    if (RST || STOP) begin
      beat_cnt <= '0;
      pkt_cnt  <= '0;
    end else if (hs_p2) begin
      beat_cnt <= beat_cnt + 1'b1;
      if (head_p2.last) pkt_cnt <= pkt_cnt + 1'b1;
    end
  end

  assign SENT_BEATS = beat_cnt;
  assign SENT_PKTS  = pkt_cnt;

`ifdef RNG_AXIS_STALL_CNT_EN
  logic [31:0] stall_cnt;

  function automatic logic [31:0] sat_inc32(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

  always_ff @(posedge CLK) begin
    if (RST || STOP)                  stall_cnt <= 32'd0;
    else if (out_vld_p2 && !M_TREADY) stall_cnt <= sat_inc32(stall_cnt);
  end

  assign STALL_CYCLES = stall_cnt;
`else
  assign STALL_CYCLES = 32'd0;
`endif

endmodule
